idu_stage: RTL and testbench
============================

# idu_stage

Registered decode stage for the single-cycle NPC core, sitting directly upstream of the ALU. Accepts 32-bit instructions from the fetch unit over a valid/ready handshake and decodes the supported subset (`addi`, `ebreak`). Presents register indices, the sign-extended I-immediate and the `add`/`ebreak` controls to the execute side through a registered output with a one-entry skid buffer. After an `ebreak` is accepted, it halts intake until reset.

## Interface
- `XLEN`, 64: datapath width; `imm_I` and `pc` width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  fetch presents an instruction.
- `in_ready`  out  1  stage can accept this cycle.
- `in_inst`  in  32  instruction word.
- `in_pc`  in  XLEN  instruction address.
- `out_valid`  out  1  decoded bundle valid.
- `out_ready`  in  1  execute consumes the bundle this cycle.
- `out_pc`  out  XLEN  pc of the decoded instruction.
- `rs1`  out  5  source register index (inst[19:15]).
- `rd`  out  5  destination index (inst[11:7]); 0 for non-`addi`.
- `imm_I`  out  XLEN  sign-extended inst[31:20].
- `add`  out  1  instruction is `addi`.
- `ebreak`  out  1  instruction is `ebreak`.
- `illegal`  out  1  instruction is outside the supported subset.
- `halted`  out  1  an `ebreak` has been accepted and intake is stopped.

## Operation
- Decode rules:
  - `addi`: opcode = 7'b0010011 and funct3 = 3'b000.
  - `ebreak`: inst == 32'h00100073 exactly.
  - Anything else is `illegal`.
- For non-`addi` entries: `rd` = 0 and `add` = 0. `imm_I` and `rs1` are always the raw field decode.
- Storage is an output register (O) plus a skid register (S), each holding {pc, rs1, rd, imm_I, add, ebreak, illegal, valid}.
- Handshakes: input fires when `in_valid && in_ready`; output fires when `out_valid && out_ready`.
- `in_ready` = !S.valid && !halted. It is derived from registers only, with no combinational path from `out_ready`.
- Per-cycle update:
  - Input fire, O empty or output fire, S empty: decoded word goes into O.
  - Input fire while O is held (valid, no output fire): decoded word goes into S.
  - Output fire with S valid: S moves to O and S clears. An input fire that cycle is impossible because `in_ready` = 0.
  - Output fire, S empty, no input fire: O.valid clears.
- Halt: `halted` sets on the cycle after an input fire whose word decodes as `ebreak`. It stays set until `rst`. Entries already in O/S still drain normally.
- Order is strictly preserved. No entry is dropped or duplicated.

## Timing
- Latency is 1 cycle: a word accepted at edge N is on the outputs after edge N, unless O is still occupied.
- Throughput is 1 per cycle when `out_ready` is held high.
- Reset values (async, immediate on `rst`):
  - `out_valid`, S.valid, `halted` = 0.
  - `out_pc`, `imm_I` = 0; `rs1`, `rd` = 0.
  - `add`, `ebreak`, `illegal` = 0.
  - `in_ready` = 1 once `rst` deasserts.
- Reset mid-transfer discards O and S contents. No partial state survives.
- Payload outputs are held stable while `out_valid && !out_ready`.

## Configuration
- `IDU_ILLEGAL_TRAP_EN` defined:
  - An accepted illegal word sets `halted` exactly like `ebreak`.
  - The word is still forwarded with `illegal` = 1.
- Not defined:
  - Illegal words pass as NOPs (`add` = 0, `ebreak` = 0, `rd` = 0, `illegal` = 1).
  - `halted` is set only by `ebreak`.

## Test plan
- Reset, then `addi x1,x0,5` (0x00500093, pc 0x80000000) with `out_ready` = 1 → next cycle: `out_valid` = 1, `rs1` = 0, `rd` = 1, `imm_I` = 5, `add` = 1, `out_pc` = 0x80000000.
- `addi x2,x1,-1` (0xfff08113) → `rs1` = 1, `rd` = 2, `imm_I` = 0xFFFFFFFFFFFFFFFF, `add` = 1.
- Back-to-back words with `out_ready` = 0 for 3 cycles → O holds word A, S holds word B, `in_ready` = 0. On release, A then B emerge in consecutive cycles, and `in_ready` returns to 1 the cycle after S drains.
- `ebreak` (0x00100073) followed by `in_valid` held high → `ebreak` = 1 on output, `halted` = 1 next cycle, `in_ready` stays 0, and the following word is never accepted.
- 0x00000033 → `illegal` = 1, `add` = 0, `rd` = 0. With `IDU_ILLEGAL_TRAP_EN`, `halted` = 1; without it, the next word is accepted normally.
- Assert `rst` while O and S are full → `out_valid` = 0 and `halted` = 0 immediately. After release, a fresh `addi` decodes correctly with 1-cycle latency.

Source files
------------

// File: rtl/idu_stage.sv
// Registered addi/ebreak decode stage with an output register plus one-entry skid buffer.
// Optional build macro IDU_ILLEGAL_TRAP_EN: an accepted illegal word halts intake like ebreak.
module idu_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      rs1,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] imm_I,
    output logic            add,
    output logic            ebreak,
    output logic            illegal,
    output logic            halted
);

    localparam logic [6:0]  OPC_OP_IMM  = 7'b0010011;
    localparam logic [2:0]  F3_ADDI     = 3'b000;
    localparam logic [31:0] INST_EBREAK = 32'h00100073;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            add;
        logic            ebreak;
        logic            illegal;
    } entry_t;

    entry_t r_o;
    entry_t r_s;
    logic   r_o_valid;
    logic   r_s_valid;
    logic   r_halted;

    entry_t w_dec;
    logic   w_is_addi;
    logic   w_is_ebreak;
    logic   w_in_fire;
    logic   w_out_fire;
    logic   w_halt_trig;

    // Handshake: a transfer happens on a rising edge where valid && ready are both high.
    // in_ready depends only on registers, so upstream never sees a path from out_ready.
    assign in_ready   = !r_s_valid && !r_halted;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_o_valid && out_ready;

    assign w_is_addi   = (in_inst[6:0] == OPC_OP_IMM) && (in_inst[14:12] == F3_ADDI);
    assign w_is_ebreak = (in_inst == INST_EBREAK);

    always_comb begin
        w_dec         = '0;
        w_dec.pc      = in_pc;
        w_dec.rs1     = in_inst[19:15];
        w_dec.rd      = w_is_addi ? in_inst[11:7] : 5'd0;
        w_dec.imm     = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
        w_dec.add     = w_is_addi;
        w_dec.ebreak  = w_is_ebreak;
        w_dec.illegal = !w_is_addi && !w_is_ebreak;
    end

`ifdef IDU_ILLEGAL_TRAP_EN
    assign w_halt_trig = w_dec.ebreak || w_dec.illegal;
`else
    assign w_halt_trig = w_dec.ebreak;
`endif

    // S only ever fills while O is stalled, and in_ready is low while S is full,
    // so an S->O refill never coincides with an input transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_o       <= '0;
            r_s       <= '0;
            r_o_valid <= 1'b0;
            r_s_valid <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            if (r_s_valid) begin
                if (w_out_fire) begin
                    r_o       <= r_s;
                    r_s_valid <= 1'b0;
                end
            end else if (w_in_fire) begin
                if (!r_o_valid || w_out_fire) begin
                    r_o       <= w_dec;
                    r_o_valid <= 1'b1;
                end else begin
                    r_s       <= w_dec;
                    r_s_valid <= 1'b1;
                end
            end else if (w_out_fire) begin
                r_o_valid <= 1'b0;
            end

            if (w_in_fire && w_halt_trig) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign out_valid = r_o_valid;
    assign out_pc    = r_o.pc;
    assign rs1       = r_o.rs1;
    assign rd        = r_o.rd;
    assign imm_I     = r_o.imm;
    assign add       = r_o.add;
    assign ebreak    = r_o.ebreak;
    assign illegal   = r_o.illegal;
    assign halted    = r_halted;

endmodule

// File: tb/tb_idu_stage.sv
// Directed self-checking bench for idu_stage: decode, skid stall, halt, illegal handling, reset.
module tb_idu_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic [63:0] imm_I;
    logic        add;
    logic        ebreak;
    logic        illegal;
    logic        halted;

    int total = 0;
    int bad   = 0;

    // Observed bundle: {valid, pc, rs1, rd, imm, add, ebreak, illegal}
    logic [141:0] w_obs;
    assign w_obs = {out_valid, out_pc, rs1, rd, imm_I, add, ebreak, illegal};

    localparam logic [141:0] EXP_A = {1'b1, 64'h100, 5'd0, 5'd3, 64'd7, 3'b100};
    localparam logic [141:0] EXP_B = {1'b1, 64'h104, 5'd3, 5'd4, 64'd9, 3'b100};
    localparam logic [141:0] EXP_C = {1'b1, 64'h108, 5'd0, 5'd5, 64'd10, 3'b100};
    localparam logic [141:0] EXP_E = {1'b1, 64'h300, 5'd0, 5'd0, 64'd1, 3'b010};

    idu_stage #(.XLEN(64)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .rs1(rs1), .rd(rd), .imm_I(imm_I),
        .add(add), .ebreak(ebreak), .illegal(illegal), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] inst, input logic [63:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
        #3;
        total++;
        if (w_obs !== 142'd0) begin bad++; $display("FAIL reset_bundle got=%h exp=0", w_obs); end
        total++;
        if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%b exp=0", halted); end
        step();
        rst = 1'b0;
        step();
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_release in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_addi();
        out_ready = 1'b1;
        send(32'h00500093, 64'h80000000);
        total++;
        if (w_obs !== {1'b1, 64'h80000000, 5'd0, 5'd1, 64'd5, 3'b100}) begin
            bad++; $display("FAIL addi_pos got=%h exp=%h", w_obs, {1'b1, 64'h80000000, 5'd0, 5'd1, 64'd5, 3'b100});
        end
        send(32'hfff08113, 64'h80000004);
        total++;
        if (w_obs !== {1'b1, 64'h80000004, 5'd1, 5'd2, 64'hFFFFFFFFFFFFFFFF, 3'b100}) begin
            bad++; $display("FAIL addi_neg got=%h exp=%h", w_obs, {1'b1, 64'h80000004, 5'd1, 5'd2, 64'hFFFFFFFFFFFFFFFF, 3'b100});
        end
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL addi_drain out_valid=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        send(32'h00700193, 64'h100);
        send(32'h00918213, 64'h104);
        in_valid = 1'b1; in_inst = 32'h00a00293; in_pc = 64'h108;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (w_obs !== EXP_A || in_ready !== 1'b0) begin
                bad++; $display("FAIL b2b_hold%0d got=%h in_ready=%b exp=%h in_ready=0", i, w_obs, in_ready, EXP_A);
            end
            if (i < 2) step();
        end
        out_ready = 1'b1;
        step();
        total++;
        if (w_obs !== EXP_B || in_ready !== 1'b1) begin
            bad++; $display("FAIL b2b_second got=%h in_ready=%b exp=%h in_ready=1", w_obs, in_ready, EXP_B);
        end
        step();
        in_valid = 1'b0;
        total++;
        if (w_obs !== EXP_C) begin bad++; $display("FAIL b2b_third got=%h exp=%h", w_obs, EXP_C); end
        step();
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain out_valid=%b exp=0", out_valid); end
    endtask

    task automatic test_illegal();
        logic [31:0] words [4];
        logic [4:0]  e_rs1 [4];
        logic [63:0] e_imm [4];
        logic [141:0] exp_v;
        words[0] = 32'h00000033; e_rs1[0] = 5'd0; e_imm[0] = 64'd0;
        words[1] = 32'h002081b3; e_rs1[1] = 5'd1; e_imm[1] = 64'd2;
        words[2] = 32'h00502093; e_rs1[2] = 5'd0; e_imm[2] = 64'd5;
        words[3] = 32'h00000073; e_rs1[3] = 5'd0; e_imm[3] = 64'd0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(words[i], 64'h200 + 64'(4 * i));
            exp_v = {1'b1, 64'h200 + 64'(4 * i), e_rs1[i], 5'd0, e_imm[i], 3'b001};
            total++;
            if (w_obs !== exp_v) begin bad++; $display("FAIL illegal%0d got=%h exp=%h", i, w_obs, exp_v); end
`ifdef IDU_ILLEGAL_TRAP_EN
            total++;
            if (halted !== 1'b1 || in_ready !== 1'b0) begin
                bad++; $display("FAIL illegal_trap%0d halted=%b in_ready=%b exp 1/0", i, halted, in_ready);
            end
            do_reset();
`else
            total++;
            if (halted !== 1'b0 || in_ready !== 1'b1) begin
                bad++; $display("FAIL illegal_nop%0d halted=%b in_ready=%b exp 0/1", i, halted, in_ready);
            end
`endif
        end
`ifndef IDU_ILLEGAL_TRAP_EN
        send(32'h00700193, 64'h100);
        total++;
        if (w_obs !== EXP_A) begin bad++; $display("FAIL illegal_next got=%h exp=%h", w_obs, EXP_A); end
`endif
        step();
    endtask

    task automatic test_ebreak();
        out_ready = 1'b1;
        send(32'h00100073, 64'h300);
        total++;
        if (w_obs !== EXP_E) begin bad++; $display("FAIL ebreak_bundle got=%h exp=%h", w_obs, EXP_E); end
        total++;
        if (halted !== 1'b1 || in_ready !== 1'b0) begin
            bad++; $display("FAIL ebreak_halt halted=%b in_ready=%b exp 1/0", halted, in_ready);
        end
        in_valid = 1'b1; in_inst = 32'h00700193; in_pc = 64'h100;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (out_valid !== 1'b0 || halted !== 1'b1 || in_ready !== 1'b0) begin
                bad++; $display("FAIL ebreak_blocked%0d out_valid=%b halted=%b in_ready=%b exp 0/1/0", i, out_valid, halted, in_ready);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b0;
        send(32'h00700193, 64'h100);
        send(32'h00100073, 64'h300);
        total++;
        if (w_obs !== EXP_A || in_ready !== 1'b0 || halted !== 1'b1) begin
            bad++; $display("FAIL mid_full got=%h in_ready=%b halted=%b exp=%h 0/1", w_obs, in_ready, halted, EXP_A);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (w_obs !== 142'd0 || halted !== 1'b0) begin
            bad++; $display("FAIL mid_async got=%h halted=%b exp=0 0", w_obs, halted);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send(32'h00a00293, 64'h108);
        total++;
        if (w_obs !== EXP_C) begin bad++; $display("FAIL mid_fresh got=%h exp=%h", w_obs, EXP_C); end
        step();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL mid_drain out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_illegal();
        test_ebreak();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
